// File: rtl/div_if.sv
// Issue/result bundle between EX and the divide sequencer.
// start_i is held by EX and stalls EX through stall_o until the request is accepted. ready_o is a one-cycle strobe. While it is high, hi_o/lo_o carry the result and EX must commit it that cycle.
interface div_if #(
  parameter int DATA_W = 32
);
  logic              start_i;
  logic              signed_i;
  logic              annul_i;
  logic [DATA_W-1:0] opdata1_i;
  logic [DATA_W-1:0] opdata2_i;
  logic              stall_o;
  logic              ready_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic [1:0]        state_dbg;

  modport master (
    output start_i, signed_i, annul_i, opdata1_i, opdata2_i,
    input  stall_o, ready_o, hi_o, lo_o, state_dbg
  );

  modport slave (
    input  start_i, signed_i, annul_i, opdata1_i, opdata2_i,
    output stall_o, ready_o, hi_o, lo_o, state_dbg
  );
endinterface

// File: rtl/div_ctrl.sv
// Restoring 1-bit-per-cycle DIV/DIVU sequencer producing HI (remainder) and LO (quotient).
// Operands are reduced to magnitudes on acceptance and the signs are reapplied on the edge into DONE.
module div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] dvd;       // dividend magnitude, shifts out MSB-first, quotient shifts in
  logic [DATA_W-1:0] dvs;
  logic [DATA_W-1:0] rem;
  logic              neg_q;
  logic              neg_r;
  logic              ready;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  logic              stall;
  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W:0]   shifted;
  logic [DATA_W+1:0] diff;
  logic              q_bit;
  logic [DATA_W-1:0] q_next;
  logic [DATA_W-1:0] r_next;
  logic [DATA_W-1:0] q_fix;
  logic [DATA_W-1:0] r_fix;
  logic              unused_diff_bit;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          stall      = 1'b1;
          state_next = (bus.opdata2_i == '0) ? BYZERO : RUN;
        end
      end
      BYZERO: begin
        stall      = 1'b1;
        state_next = bus.annul_i ? IDLE : DONE;
      end
      RUN: begin
        stall = 1'b1;
        if (bus.annul_i)                          state_next = IDLE;
        else if (cnt == CNT_W'(DATA_W - 1))       state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    a_neg   = bus.signed_i & bus.opdata1_i[DATA_W-1];
    b_neg   = bus.signed_i & bus.opdata2_i[DATA_W-1];
    a_mag   = a_neg ? -bus.opdata1_i : bus.opdata1_i;
    b_mag   = b_neg ? -bus.opdata2_i : bus.opdata2_i;
    // One extra bit on the shifted remainder so a full-width magnitude never overflows.
    shifted = {rem, dvd[DATA_W-1]};
    diff    = {1'b0, shifted} - {2'b00, dvs};
    q_bit   = ~diff[DATA_W+1];
    q_next  = {dvd[DATA_W-2:0], q_bit};
    r_next  = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    q_fix   = neg_q ? -q_next : q_next;
    r_fix   = neg_r ? -r_next : r_next;
  end

  // A non-negative difference is always below the divisor, so its top bit is zero.
  assign unused_diff_bit = diff[DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      ready <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      ready <= (state_next == DONE);
      if (state == IDLE && state_next == RUN) begin
        cnt   <= '0;
        rem   <= '0;
        dvd   <= a_mag;
        dvs   <= b_mag;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
      end else if (state == RUN && state_next == RUN) begin
        cnt <= cnt + 1'b1;
        dvd <= q_next;
        rem <= r_next;
      end
      if (state == BYZERO && state_next == DONE) begin
        hi <= '0;
        lo <= '0;
      end else if (state == RUN && state_next == DONE) begin
        hi <= r_fix;
        lo <= q_fix;
      end
    end
  end

  assign bus.stall_o   = stall;
  assign bus.ready_o   = ready;
  assign bus.hi_o      = hi;
  assign bus.lo_o      = lo;
  assign bus.state_dbg = state;
endmodule
